// File: rtl/cntr_ctrl_pkg.sv
// Shared types and constants for the command-driven counter controller.
package cntr_ctrl_pkg;

   // Controller states; the encoding is exported on state_o for debug.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Command opcodes carried on cmd_op.
   localparam logic [1:0] OP_START  = 2'd0;
   localparam logic [1:0] OP_STOP   = 2'd1;
   localparam logic [1:0] OP_RESUME = 2'd2;
   localparam logic [1:0] OP_CLEAR  = 2'd3;

endpackage

// File: rtl/cntr_ctrl_count.sv
// WIDTH-bit count register with clear/increment/hold and terminal compare.
module cntr_ctrl_count #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [WIDTH-1:0] term,
   output logic [WIDTH-1:0] count,
   output logic             eq
);

   logic [WIDTH-1:0] count_reg;

   // Clear has priority over increment; otherwise the count holds.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_reg <= '0;
      end else if (inc) begin
         count_reg <= count_reg + WIDTH'(1'b1);
      end
   end

   assign count = count_reg;
   assign eq    = (count_reg == term);

endmodule

// File: rtl/cntr_ctrl.sv
// Command decode, run/pause/done FSM and terminal-count pulse for an up-counter.
module cntr_ctrl
   import cntr_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_term,
   input  logic             cmd_reload,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             done,
   output logic [1:0]       state_o
);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] term_reg;
   logic             reload_reg;
   logic             done_reg, done_next;
   logic             load;
   logic             cnt_clr, cnt_inc;
   logic             cnt_eq;
   logic             accept;

   // The only combinational output path: no back-pressure outside reset.
   assign cmd_ready = !rst;
   assign accept    = cmd_valid && cmd_ready;

   cntr_ctrl_count #(
      .WIDTH (WIDTH)
   ) u_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .term  (term_reg),
      .count (count),
      .eq    (cnt_eq)
   );

   // State, terminal configuration and done pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         term_reg   <= '0;
         reload_reg <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_next;
         if (load) begin
            term_reg   <= cmd_term;
            reload_reg <= cmd_reload;
         end
      end
   end

   // Next-state and datapath controls; an accepted command always swallows the tick.
   always_comb begin
      state_next = state_reg;
      done_next  = 1'b0;
      load       = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      if (accept) begin
         case (cmd_op)
            OP_START: begin
               load       = 1'b1;
               cnt_clr    = 1'b1;
               state_next = ST_RUN;
            end
            OP_STOP: begin
               if (state_reg == ST_RUN) state_next = ST_PAUSE;
            end
            OP_RESUME: begin
               if (state_reg == ST_PAUSE) state_next = ST_RUN;
            end
            default: begin
               cnt_clr    = 1'b1;
               state_next = ST_IDLE;
            end
         endcase
      end else if (state_reg == ST_RUN && tick) begin
         if (cnt_eq) begin
            done_next = 1'b1;
            if (reload_reg) begin
               cnt_clr = 1'b1;
            end else begin
               state_next = ST_DONE;
            end
         end else begin
            cnt_inc = 1'b1;
         end
      end
   end

   assign running = (state_reg == ST_RUN);
   assign done    = done_reg;
   assign state_o = state_reg;

endmodule
